// File: rtl/bibp_sirali.sv
// ---------------------------------------------------------------------------
// bibp_sirali
//   Sequential ALU. One instruction word {opcode, v1, v2} is taken over a
//   valid/ready handshake. ADD/SUB/AND/OR/XOR/SHL/SHR finish in one clock;
//   MUL is an iterative shift-add multiplier (one step per clock). The result
//   and its zero/carry flags are held until the consumer takes them.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   the producer's valid and the receiver's ready are both 1. Valid/data are
//   never looked at while ready is 0; once sonuc_gecerli is 1, sonuc, sifir
//   and tasma do not change until the edge that transfers them.
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous reset, active-low
//   buyruk          in   {opcode[2:0], v1[U-1:0], v2[U-1:0]}
//   buyruk_gecerli  in   buyruk valid
//   buyruk_hazir    out  ready for a new buyruk (idle)
//   sonuc           out  registered 2*U-bit result
//   sonuc_gecerli   out  sonuc/flags valid
//   sonuc_hazir     in   consumer takes the result
//   sifir           out  sonuc == 0
//   tasma           out  carry/borrow/shift-out/overflow flag
//   mesgul          out  not idle
// ---------------------------------------------------------------------------
module bibp_sirali #(
    parameter int UZUNLUK = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*UZUNLUK+2:0]   buyruk,
    input  logic                   buyruk_gecerli,
    output logic                   buyruk_hazir,
    output logic [2*UZUNLUK-1:0]   sonuc,
    output logic                   sonuc_gecerli,
    input  logic                   sonuc_hazir,
    output logic                   sifir,
    output logic                   tasma,
    output logic                   mesgul
);

    localparam int U  = UZUNLUK;
    localparam int W  = 2 * UZUNLUK;
    localparam int SW = (U > 2) ? $clog2(U) : 1;

    localparam logic [SW-1:0] SAYAC_SON = SW'(U - 1);
    localparam logic [U-1:0]  U_DEGER   = U[U-1:0];

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        CARP  = 2'd1,
        CIKIS = 2'd2
    } durum_t;

    durum_t durum, sonraki;

    // Instruction fields
    logic [2:0]   opcode;
    logic [U-1:0] v1, v2;
    assign opcode = buyruk[W+2:W];
    assign v1     = buyruk[W-1:U];
    assign v2     = buyruk[U-1:0];

    logic kabul;
    assign kabul = buyruk_gecerli && (durum == BOS);

    // Result / flag registers
    logic [W-1:0] sonuc_r;
    logic         sifir_r, tasma_r;

    // Multiplier registers
    logic [W-1:0]  carpilan;   // multiplicand, shifted left each step
    logic [U-1:0]  carpan;     // multiplier, shifted right each step
    logic [W-1:0]  birikim;    // partial product
    logic [SW-1:0] sayac;
    logic          son_adim;
    logic [W-1:0]  yeni_birikim;

    assign son_adim     = (sayac == SAYAC_SON);
    assign yeni_birikim = birikim + (carpan[0] ? carpilan : {W{1'b0}});

    // -----------------------------------------------------------------------
    // Single-cycle ALU
    // -----------------------------------------------------------------------
    logic [W-1:0] tek_sonuc;
    logic         tek_tasma;
    logic [U:0]   toplam;
    logic [W-1:0] sola, saga;
    logic         buyuk_kayma;

    always_comb begin
        tek_sonuc   = '0;
        tek_tasma   = 1'b0;
        buyuk_kayma = (v2 >= U_DEGER);
        toplam      = {1'b0, v1} + {1'b0, v2};
        // Shifting inside a 2U-bit window keeps the bits that fall off
        // the U-bit result, so "anything shifted out" is just an OR.
        sola        = {{U{1'b0}}, v1} << v2;
        saga        = {v1, {U{1'b0}}} >> v2;
        case (opcode)
            OP_ADD: begin
                tek_sonuc[U:0] = toplam;
                tek_tasma      = toplam[U];
            end
            OP_SUB: begin
                tek_sonuc[U-1:0] = v1 - v2;
                tek_tasma        = (v1 < v2);
            end
            OP_AND: tek_sonuc[U-1:0] = v1 & v2;
            OP_OR:  tek_sonuc[U-1:0] = v1 | v2;
            OP_XOR: tek_sonuc[U-1:0] = v1 ^ v2;
            OP_SHL: begin
                if (buyuk_kayma) begin
                    tek_tasma = |v1;
                end else begin
                    tek_sonuc[U-1:0] = sola[U-1:0];
                    tek_tasma        = |sola[W-1:U];
                end
            end
            OP_SHR: begin
                if (buyuk_kayma) begin
                    tek_tasma = |v1;
                end else begin
                    tek_sonuc[U-1:0] = saga[W-1:U];
                    tek_tasma        = |saga[U-1:0];
                end
            end
            default: begin
                tek_sonuc = '0;
                tek_tasma = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum <= BOS;
        end else begin
            durum <= sonraki;
        end
    end

    always_comb begin
        sonraki = durum;
        case (durum)
            BOS: begin
                if (kabul) begin
                    sonraki = (opcode == OP_MUL) ? CARP : CIKIS;
                end
            end
            CARP: begin
                if (son_adim) begin
                    sonraki = CIKIS;
                end
            end
            CIKIS: begin
                if (sonuc_hazir) begin
                    sonraki = BOS;
                end
            end
            default: sonraki = BOS;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sonuc_r  <= '0;
            sifir_r  <= 1'b0;
            tasma_r  <= 1'b0;
            carpilan <= '0;
            carpan   <= '0;
            birikim  <= '0;
            sayac    <= '0;
        end else begin
            case (durum)
                BOS: begin
                    if (kabul) begin
                        if (opcode == OP_MUL) begin
                            carpilan <= {{U{1'b0}}, v1};
                            carpan   <= v2;
                            birikim  <= '0;
                            sayac    <= '0;
                        end else begin
                            sonuc_r <= tek_sonuc;
                            sifir_r <= (tek_sonuc == '0);
                            tasma_r <= tek_tasma;
                        end
                    end
                end
                CARP: begin
                    birikim  <= yeni_birikim;
                    carpilan <= carpilan << 1;
                    carpan   <= carpan >> 1;
                    if (son_adim) begin
                        // Last step: the freshly added partial product is
                        // the full result, written straight to sonuc.
                        sayac   <= '0;
                        sonuc_r <= yeni_birikim;
                        sifir_r <= (yeni_birikim == '0);
                        tasma_r <= |yeni_birikim[W-1:U];
                    end else begin
                        sayac <= sayac + SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sonuc         = sonuc_r;
    assign sifir         = sifir_r;
    assign tasma         = tasma_r;
    assign buyruk_hazir  = (durum == BOS);
    assign sonuc_gecerli = (durum == CIKIS);
    assign mesgul        = (durum != BOS);

endmodule

// File: tb/tb_bibp_sirali.sv
// ---------------------------------------------------------------------------
// tb_bibp_sirali
//   Directed bench for bibp_sirali (UZUNLUK = 8). Inputs change on the
//   falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bibp_sirali;

    localparam int U = 8;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2*U+2:0]   buyruk;
    logic             buyruk_gecerli;
    logic             buyruk_hazir;
    logic [2*U-1:0]   sonuc;
    logic             sonuc_gecerli;
    logic             sonuc_hazir;
    logic             sifir;
    logic             tasma;
    logic             mesgul;

    bibp_sirali #(.UZUNLUK(U)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .buyruk         (buyruk),
        .buyruk_gecerli (buyruk_gecerli),
        .buyruk_hazir   (buyruk_hazir),
        .sonuc          (sonuc),
        .sonuc_gecerli  (sonuc_gecerli),
        .sonuc_hazir    (sonuc_hazir),
        .sifir          (sifir),
        .tasma          (tasma),
        .mesgul         (mesgul)
    );

    int n_kontrol = 0;
    int n_hata    = 0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic saat;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single-cycle op with sonuc_hazir=1: result one clock after the
    // accept cycle, back to idle the clock after.
    task automatic tek_islem(input string ad, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] bek_sonuc, input logic bek_tasma);
        buyruk         = {op, a, b};
        buyruk_gecerli = 1'b1;
        saat();
        buyruk_gecerli = 1'b0;
        kontrol({ad, "_gecerli"}, sonuc_gecerli, 1);
        kontrol({ad, "_sonuc"}, sonuc, bek_sonuc);
        kontrol({ad, "_tasma"}, tasma, bek_tasma);
        kontrol({ad, "_sifir"}, sifir, (bek_sonuc == 16'h0000));
        kontrol({ad, "_hazir_yok"}, buyruk_hazir, 0);
        saat();
        kontrol({ad, "_bos"}, buyruk_hazir, 1);
        kontrol({ad, "_gecerli_dustu"}, sonuc_gecerli, 0);
    endtask

    // MUL: sonuc_gecerli must first appear exactly U+1 clocks after the
    // accept cycle begins, with buyruk_hazir low in between.
    task automatic carp_islem(input string ad, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] bek_sonuc, input logic bek_tasma);
        int gecikme;
        logic hazir_goruldu;
        gecikme        = 0;
        hazir_goruldu  = 1'b0;
        buyruk         = {3'b111, a, b};
        buyruk_gecerli = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            saat();
            buyruk_gecerli = 1'b0;
            if (sonuc_gecerli) begin
                gecikme = k;
                break;
            end
            if (buyruk_hazir) hazir_goruldu = 1'b1;
        end
        kontrol({ad, "_gecikme"}, gecikme, U + 1);
        kontrol({ad, "_hazir_dusuk"}, hazir_goruldu, 0);
        kontrol({ad, "_sonuc"}, sonuc, bek_sonuc);
        kontrol({ad, "_tasma"}, tasma, bek_tasma);
        kontrol({ad, "_sifir"}, sifir, (bek_sonuc == 16'h0000));
        saat();
        kontrol({ad, "_bos"}, mesgul, 0);
    endtask

    initial begin
        int gecerli_sayisi;

        rst_n          = 1'b0;
        buyruk         = '0;
        buyruk_gecerli = 1'b0;
        sonuc_hazir    = 1'b0;

        // 1: reset held for two clocks
        saat();
        saat();
        rst_n = 1'b1;
        kontrol("rst_sonuc", sonuc, 0);
        kontrol("rst_gecerli", sonuc_gecerli, 0);
        kontrol("rst_tasma", tasma, 0);
        kontrol("rst_sifir", sifir, 0);
        kontrol("rst_hazir", buyruk_hazir, 1);
        kontrol("rst_mesgul", mesgul, 0);

        // 2, 3, 5: single-cycle ops
        sonuc_hazir = 1'b1;
        tek_islem("add_ff_01",  3'b000, 8'hFF, 8'h01, 16'h0100, 1'b1);
        tek_islem("add_12_34",  3'b000, 8'h12, 8'h34, 16'h0046, 1'b0);
        tek_islem("sub_03_05",  3'b001, 8'h03, 8'h05, 16'h00FE, 1'b1);
        tek_islem("sub_05_03",  3'b001, 8'h05, 8'h03, 16'h0002, 1'b0);
        tek_islem("xor_a5_a5",  3'b100, 8'hA5, 8'hA5, 16'h0000, 1'b0);
        tek_islem("and_f0_3c",  3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0);
        tek_islem("or_f0_0f",   3'b011, 8'hF0, 8'h0F, 16'h00FF, 1'b0);
        tek_islem("shl_81_1",   3'b101, 8'h81, 8'h01, 16'h0002, 1'b1);
        tek_islem("shl_0f_4",   3'b101, 8'h0F, 8'h04, 16'h00F0, 1'b0);
        tek_islem("shl_01_8",   3'b101, 8'h01, 8'h08, 16'h0000, 1'b1);
        tek_islem("shr_80_9",   3'b110, 8'h80, 8'h09, 16'h0000, 1'b1);
        tek_islem("shr_81_1",   3'b110, 8'h81, 8'h01, 16'h0040, 1'b1);
        tek_islem("shr_f0_4",   3'b110, 8'hF0, 8'h04, 16'h000F, 1'b0);
        tek_islem("shr_00_9",   3'b110, 8'h00, 8'h09, 16'h0000, 1'b0);

        // 4: multiply
        carp_islem("mul_ff_ff", 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        carp_islem("mul_0d_0b", 8'h0D, 8'h0B, 16'h008F, 1'b0);
        carp_islem("mul_00_7f", 8'h00, 8'h7F, 16'h0000, 1'b0);
        carp_islem("mul_80_02", 8'h80, 8'h02, 16'h0100, 1'b1);

        // 6a: backpressure, new buyruk driven while result is held
        sonuc_hazir    = 1'b0;
        buyruk         = {3'b000, 8'h01, 8'h02};
        buyruk_gecerli = 1'b1;
        saat();
        kontrol("bp_ilk_gecerli", sonuc_gecerli, 1);
        kontrol("bp_ilk_sonuc", sonuc, 16'h0003);
        buyruk = {3'b011, 8'hFF, 8'hFF};
        for (int k = 0; k < 5; k++) begin
            saat();
            kontrol("bp_gecerli", sonuc_gecerli, 1);
            kontrol("bp_sonuc", sonuc, 16'h0003);
            kontrol("bp_tasma", tasma, 0);
            kontrol("bp_sifir", sifir, 0);
            kontrol("bp_hazir", buyruk_hazir, 0);
        end
        buyruk_gecerli = 1'b0;
        sonuc_hazir    = 1'b1;
        saat();
        kontrol("bp_bos", mesgul, 0);
        kontrol("bp_gecerli_dustu", sonuc_gecerli, 0);
        kontrol("bp_sonuc_korundu", sonuc, 16'h0003);

        // 6b: reset four clocks into a multiply
        buyruk         = {3'b111, 8'h07, 8'h09};
        buyruk_gecerli = 1'b1;
        for (int k = 0; k < 4; k++) begin
            saat();
            buyruk_gecerli = 1'b0;
        end
        kontrol("rm_carp_mesgul", mesgul, 1);
        rst_n = 1'b0;
        saat();
        rst_n = 1'b1;
        kontrol("rm_bos", mesgul, 0);
        kontrol("rm_hazir", buyruk_hazir, 1);
        kontrol("rm_sonuc", sonuc, 0);
        gecerli_sayisi = 0;
        for (int k = 0; k < 12; k++) begin
            if (sonuc_gecerli) gecerli_sayisi++;
            saat();
        end
        kontrol("rm_gecerli_yok", gecerli_sayisi, 0);

        // Normal operation after the aborted multiply
        tek_islem("add_rst_sonra", 3'b000, 8'h01, 8'h01, 16'h0002, 1'b0);
        carp_islem("mul_rst_sonra", 8'h10, 8'h10, 16'h0100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
        $finish;
    end

endmodule
